// File: rtl/tl_miss_ctrl_pkg.sv
// Shared types for the TileLink miss controller: channel structs, BundleParam
// encodings, the controller state enum and the Edge message builders.
package tl_miss_ctrl_pkg;

  localparam int unsigned ADDR_BITS   = 32;
  localparam int unsigned DATA_BITS   = 32;
  localparam int unsigned SOURCE_BITS = 4;
  localparam int unsigned SINK_BITS   = 4;
  localparam int unsigned SIZE_BITS   = 4;
  localparam int unsigned PARAM_BITS  = 3;
  localparam int unsigned BEAT_BITS   = 2;

  typedef logic [BEAT_BITS-1:0] beat_t;

  typedef enum logic [2:0] {IDLE, REL, REL_WAIT, ACQ, GRANT, ACK, PACK} state_t;

  // BundleParam: grow (A), cap (D), shrink/report (C)
  localparam logic [2:0] NTOB = 3'd0, NTOT = 3'd1, BTOT = 3'd2;
  localparam logic [1:0] TOT  = 2'd0, TOB  = 2'd1, TON  = 2'd2;
  localparam logic [2:0] TTOB = 3'd0, TTON = 3'd1, BTON = 3'd2,
                         TTOT = 3'd3, BTOB = 3'd4, NTON = 3'd5;

  localparam logic [2:0] A_ACQUIRE_BLOCK   = 3'd6;
  localparam logic [2:0] B_PROBE           = 3'd6;
  localparam logic [2:0] C_PROBE_ACK       = 3'd4;
  localparam logic [2:0] C_RELEASE_DATA    = 3'd7;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] D_GRANT           = 3'd4;
  localparam logic [2:0] D_GRANT_DATA      = 3'd5;
  localparam logic [2:0] D_RELEASE_ACK     = 3'd6;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [PARAM_BITS-1:0]  param;
    logic [SIZE_BITS-1:0]   size;
    logic [SOURCE_BITS-1:0] source;
    logic [ADDR_BITS-1:0]   address;
    logic [DATA_BITS/8-1:0] mask;
    logic [DATA_BITS-1:0]   data;
  } a_t;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [PARAM_BITS-1:0]  param;
    logic [SIZE_BITS-1:0]   size;
    logic [SOURCE_BITS-1:0] source;
    logic [ADDR_BITS-1:0]   address;
  } b_t;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [PARAM_BITS-1:0]  param;
    logic [SIZE_BITS-1:0]   size;
    logic [SOURCE_BITS-1:0] source;
    logic [ADDR_BITS-1:0]   address;
    logic [DATA_BITS-1:0]   data;
  } c_t;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [PARAM_BITS-1:0]  param;
    logic [SIZE_BITS-1:0]   size;
    logic [SOURCE_BITS-1:0] source;
    logic [SINK_BITS-1:0]   sink;
    logic                   denied;
    logic [DATA_BITS-1:0]   data;
  } d_t;

  typedef struct packed {
    logic [SINK_BITS-1:0] sink;
  } e_t;

  function automatic a_t acquire_block(input logic [SOURCE_BITS-1:0] source,
                                       input logic [ADDR_BITS-1:0] address,
                                       input logic [SIZE_BITS-1:0] lg_size,
                                       input logic [PARAM_BITS-1:0] grow);
    a_t m = '0;
    m.opcode  = A_ACQUIRE_BLOCK;
    m.param   = grow;
    m.size    = lg_size;
    m.source  = source;
    m.address = address;
    m.mask    = '1;
    return m;
  endfunction

  function automatic c_t release_data(input logic [SOURCE_BITS-1:0] source,
                                      input logic [ADDR_BITS-1:0] address,
                                      input logic [SIZE_BITS-1:0] lg_size,
                                      input logic [PARAM_BITS-1:0] shrink,
                                      input logic [DATA_BITS-1:0] data);
    c_t m = '0;
    m.opcode  = C_RELEASE_DATA;
    m.param   = shrink;
    m.size    = lg_size;
    m.source  = source;
    m.address = address;
    m.data    = data;
    return m;
  endfunction

  function automatic c_t probe_ack(input logic [SOURCE_BITS-1:0] source,
                                   input logic [ADDR_BITS-1:0] address,
                                   input logic [SIZE_BITS-1:0] lg_size,
                                   input logic [PARAM_BITS-1:0] report);
    c_t m = '0;
    m.opcode  = C_PROBE_ACK;
    m.param   = report;
    m.size    = lg_size;
    m.source  = source;
    m.address = address;
    return m;
  endfunction

  function automatic e_t grant_ack(input logic [SINK_BITS-1:0] sink);
    e_t m;
    m.sink = sink;
    return m;
  endfunction

  function automatic logic has_data_d(input d_t m);
    return m.opcode[0];
  endfunction

endpackage

// File: rtl/tl_miss_ctrl_if.sv
// TileLink A-E channel bundle between the miss controller (master) and the
// next level of the memory system (slave).
interface tl_miss_ctrl_if;
  import tl_miss_ctrl_pkg::*;

  logic a_valid, a_ready;
  a_t   a;
  logic b_valid, b_ready;
  b_t   b;
  logic c_valid, c_ready;
  c_t   c;
  logic d_valid, d_ready;
  d_t   d;
  logic e_valid, e_ready;
  e_t   e;

  modport master (
    output a_valid, a, input  a_ready,
    input  b_valid, b, output b_ready,
    output c_valid, c, input  c_ready,
    input  d_valid, d, output d_ready,
    output e_valid, e, input  e_ready
  );

  modport slave (
    input  a_valid, a, output a_ready,
    output b_valid, b, input  b_ready,
    input  c_valid, c, output c_ready,
    output d_valid, d, input  d_ready,
    input  e_valid, e, output e_ready
  );
endinterface

// File: rtl/tl_miss_ctrl.sv
// Cache miss controller: optional victim Release, AcquireBlock, Grant refill
// and GrantAck, with ProbeAck service interleaved at safe points.
module tl_miss_ctrl
  import tl_miss_ctrl_pkg::*;
#(
  parameter int unsigned SOURCE_ID = 0,
  parameter int unsigned BEATS     = 4,
  parameter int unsigned LG_BLOCK  = 6,
  localparam int unsigned CW = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_BITS-1:0]  req_addr,
  input  logic [PARAM_BITS-1:0] req_grow,
  input  logic                  req_wb,
  input  logic [ADDR_BITS-1:0]  req_wb_addr,
  input  logic [PARAM_BITS-1:0] req_shrink,
  output logic [CW-1:0]         wb_beat,
  input  logic [DATA_BITS-1:0]  wb_data,
  tl_miss_ctrl_if.master        tl,
  input  logic [PARAM_BITS-1:0] probe_perm,
  output logic                  refill_valid,
  output logic [CW-1:0]         refill_beat,
  output logic [DATA_BITS-1:0]  refill_data,
  output logic                  done,
  output logic [1:0]            done_cap,
  output logic                  err
);

  localparam logic [CW-1:0]          LAST = CW'(BEATS - 1);
  localparam logic [SOURCE_BITS-1:0] SRC  = SOURCE_BITS'(SOURCE_ID);
  localparam logic [SIZE_BITS-1:0]   LG   = SIZE_BITS'(LG_BLOCK);

  state_t                state, saved;
  logic [CW-1:0]         cnt;
  logic [ADDR_BITS-1:0]  addr_q, wb_addr_q;
  logic [PARAM_BITS-1:0] grow_q, shrink_q, report_q;
  logic [SINK_BITS-1:0]  sink_q;
  b_t                    probe_q;
  logic                  a_valid_q, c_valid_q, e_valid_q;
  logic                  first_beat, grant_ok;
  logic                  req_fire, a_fire, b_fire, c_fire, d_fire, e_fire;
  logic                  unused_fields;

  assign first_beat = (cnt == '0);
  assign grant_ok   = (tl.d.opcode == D_GRANT_DATA) || (tl.d.opcode == D_GRANT && first_beat);

  // A D beat wins over a probe in the same cycle; the probe is taken next cycle.
  assign req_ready  = reset_n && state == IDLE && !tl.b_valid;
  assign tl.b_ready = reset_n && (state == IDLE ||
                      (!tl.d_valid && (state == REL_WAIT || (state == GRANT && first_beat))));
  assign tl.d_ready = (state == REL_WAIT) || (state == GRANT);

  assign tl.a_valid = a_valid_q;
  assign tl.c_valid = c_valid_q;
  assign tl.e_valid = e_valid_q;
  assign tl.a = acquire_block(SRC, addr_q, LG, grow_q);
  assign tl.c = (state == PACK) ? probe_ack(probe_q.source, probe_q.address, probe_q.size, report_q)
                                : release_data(SRC, wb_addr_q, LG, shrink_q, wb_data);
  assign tl.e = grant_ack(sink_q);
  assign wb_beat = cnt;

  assign req_fire = req_valid && req_ready;
  assign a_fire   = tl.a_valid && tl.a_ready;
  assign b_fire   = tl.b_valid && tl.b_ready;
  assign c_fire   = tl.c_valid && tl.c_ready;
  assign d_fire   = tl.d_valid && tl.d_ready;
  assign e_fire   = tl.e_valid && tl.e_ready;

  assign unused_fields = ^{tl.d.size, tl.d.source, tl.d.denied, tl.d.param[2],
                           probe_q.opcode, probe_q.param};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      saved        <= IDLE;
      cnt          <= '0;
      addr_q       <= '0;
      wb_addr_q    <= '0;
      grow_q       <= '0;
      shrink_q     <= '0;
      report_q     <= '0;
      sink_q       <= '0;
      probe_q      <= '0;
      a_valid_q    <= 1'b0;
      c_valid_q    <= 1'b0;
      e_valid_q    <= 1'b0;
      refill_valid <= 1'b0;
      refill_beat  <= '0;
      refill_data  <= '0;
      done         <= 1'b0;
      done_cap     <= '0;
      err          <= 1'b0;
    end else begin
      done         <= 1'b0;
      refill_valid <= 1'b0;
      if (b_fire) begin
        probe_q   <= tl.b;
        report_q  <= probe_perm;
        saved     <= state;
        state     <= PACK;
        c_valid_q <= 1'b1;
      end else begin
        case (state)
          IDLE: if (req_fire) begin
            addr_q    <= req_addr;
            grow_q    <= req_grow;
            wb_addr_q <= req_wb_addr;
            shrink_q  <= req_shrink;
            cnt       <= '0;
            if (req_wb) begin
              state     <= REL;
              c_valid_q <= 1'b1;
            end else begin
              state     <= ACQ;
              a_valid_q <= 1'b1;
            end
          end
          REL: if (c_fire) begin
            if (cnt == LAST) begin
              cnt       <= '0;
              c_valid_q <= 1'b0;
              state     <= REL_WAIT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          REL_WAIT: if (d_fire) begin
            if (tl.d.opcode == D_RELEASE_ACK) begin
              state     <= ACQ;
              a_valid_q <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
          ACQ: if (a_fire) begin
            a_valid_q <= 1'b0;
            cnt       <= '0;
            state     <= GRANT;
          end
          GRANT: if (d_fire) begin
            if (grant_ok) begin
              if (first_beat) begin
                sink_q   <= tl.d.sink;
                done_cap <= tl.d.param[1:0];
              end
              if (has_data_d(tl.d)) begin
                refill_valid <= 1'b1;
                refill_beat  <= cnt;
                refill_data  <= tl.d.data;
                if (cnt == LAST) begin
                  cnt       <= '0;
                  e_valid_q <= 1'b1;
                  state     <= ACK;
                end else begin
                  cnt <= cnt + 1'b1;
                end
              end else begin
                e_valid_q <= 1'b1;
                state     <= ACK;
              end
            end else begin
              err <= 1'b1;
            end
          end
          ACK: if (e_fire) begin
            e_valid_q <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
          PACK: if (c_fire) begin
            c_valid_q <= 1'b0;
            state     <= saved;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tl_miss_ctrl.sv
// Directed bench for tl_miss_ctrl: refill, victim release, probe interleave,
// probe/request priority, D protocol error and mid-transaction reset.
module tb_tl_miss_ctrl;
  import tl_miss_ctrl_pkg::*;

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic                  req_valid, req_ready, req_wb;
  logic [ADDR_BITS-1:0]  req_addr, req_wb_addr;
  logic [PARAM_BITS-1:0] req_grow, req_shrink, probe_perm;
  logic [1:0]            wb_beat, refill_beat, done_cap;
  logic [DATA_BITS-1:0]  wb_data, refill_data;
  logic                  refill_valid, done, err;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int a_cnt    = 0;
  int c_cnt    = 0;
  int c0, a0;

  tl_miss_ctrl_if tl();

  tl_miss_ctrl #(.SOURCE_ID(2), .BEATS(4), .LG_BLOCK(6)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_grow(req_grow), .req_wb(req_wb), .req_wb_addr(req_wb_addr),
    .req_shrink(req_shrink), .wb_beat(wb_beat), .wb_data(wb_data),
    .tl(tl.master), .probe_perm(probe_perm),
    .refill_valid(refill_valid), .refill_beat(refill_beat), .refill_data(refill_data),
    .done(done), .done_cap(done_cap), .err(err)
  );

  always #5 clock = ~clock;

  // Victim data is a pure function of the beat index the DUT requests.
  assign wb_data = 32'hCAFE_0000 + 32'(wb_beat);

  always @(posedge clock) begin
    if (tl.a_valid && tl.a_ready) a_cnt <= a_cnt + 1;
    if (tl.c_valid && tl.c_ready) c_cnt <= c_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_d(input logic [2:0] op, input logic [2:0] prm,
                         input logic [3:0] snk, input logic [31:0] dat);
    tl.d        = '0;
    tl.d.opcode = op;
    tl.d.param  = prm;
    tl.d.sink   = snk;
    tl.d.data   = dat;
    tl.d_valid  = 1'b1;
    @(negedge clock);
    tl.d_valid  = 1'b0;
  endtask

  task automatic send_req(input logic [31:0] addr, input logic [2:0] grow, input logic wb,
                          input logic [31:0] wb_addr, input logic [2:0] shrink);
    req_valid = 1'b1; req_addr = addr; req_grow = grow;
    req_wb = wb; req_wb_addr = wb_addr; req_shrink = shrink;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic a_hs();
    tl.a_ready = 1'b1;
    @(negedge clock);
    tl.a_ready = 1'b0;
  endtask

  task automatic e_hs();
    tl.e_ready = 1'b1;
    @(negedge clock);
    tl.e_ready = 1'b0;
  endtask

  task automatic set_probe(input logic [3:0] src, input logic [31:0] addr);
    tl.b         = '0;
    tl.b.opcode  = B_PROBE;
    tl.b.param   = 3'd2;
    tl.b.size    = 4'd6;
    tl.b.source  = src;
    tl.b.address = addr;
    tl.b_valid   = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_wb = 1'b0; req_addr = '0; req_wb_addr = '0;
    req_grow = '0; req_shrink = '0; probe_perm = '0;
    tl.a_ready = 1'b0; tl.b_valid = 1'b0; tl.b = '0; tl.c_ready = 1'b0;
    tl.d_valid = 1'b0; tl.d = '0; tl.e_ready = 1'b0;
    repeat (2) @(negedge clock);

    chk("rst_req_ready", req_ready, 0);
    chk("rst_b_ready", tl.b_ready, 0);
    chk("rst_d_ready", tl.d_ready, 0);
    chk("rst_valids", {tl.a_valid, tl.c_valid, tl.e_valid}, 0);
    chk("rst_done_refill", {done, refill_valid}, 0);
    chk("rst_err", err, 0);
    chk("rst_done_cap", done_cap, 0);
    chk("rst_wb_beat", wb_beat, 0);
    reset_n = 1'b1;

    // Plain miss with 4-beat GrantData
    req_valid = 1'b1; req_addr = 32'h1000; req_grow = NTOT; req_wb = 1'b0;
    #1 chk("t1_req_ready", req_ready, 1);
    @(negedge clock);
    req_valid = 1'b0;
    chk("t1_a_valid", tl.a_valid, 1);
    chk("t1_a_opcode", tl.a.opcode, A_ACQUIRE_BLOCK);
    chk("t1_a_param", tl.a.param, NTOT);
    chk("t1_a_addr", tl.a.address, 32'h1000);
    chk("t1_a_size", tl.a.size, 6);
    chk("t1_a_source", tl.a.source, 2);
    @(negedge clock);
    chk("t1_a_hold_valid", tl.a_valid, 1);
    chk("t1_a_hold_addr", tl.a.address, 32'h1000);
    a_hs();
    chk("t1_a_cnt", a_cnt, 1);
    chk("t1_a_drop", tl.a_valid, 0);
    chk("t1_d_ready", tl.d_ready, 1);
    for (int i = 0; i < 4; i++) begin
      drive_d(D_GRANT_DATA, {1'b0, TOT}, 4'd3, 32'hD000_0000 + i);
      chk("t1_refill_valid", refill_valid, 1);
      chk("t1_refill_beat", refill_beat, i);
      chk("t1_refill_data", refill_data, 32'hD000_0000 + i);
    end
    chk("t1_e_valid", tl.e_valid, 1);
    chk("t1_e_sink", tl.e.sink, 3);
    e_hs();
    chk("t1_done", done, 1);
    chk("t1_done_cap", done_cap, TOT);
    chk("t1_e_drop", tl.e_valid, 0);
    @(negedge clock);
    chk("t1_done_pulse", done, 0);
    chk("t1_a_total", a_cnt, 1);

    // Victim release with c_ready stalls, then Grant without data
    req_valid = 1'b1; req_addr = 32'h3000; req_grow = BTOT;
    req_wb = 1'b1; req_wb_addr = 32'h2000; req_shrink = TTON;
    @(negedge clock);
    req_valid = 1'b0;
    c0 = c_cnt;
    #1;
    chk("t2_c_opcode", tl.c.opcode, C_RELEASE_DATA);
    chk("t2_c_param", tl.c.param, TTON);
    chk("t2_c_addr", tl.c.address, 32'h2000);
    chk("t2_c_source", tl.c.source, 2);
    for (int i = 0; i < 4; i++) begin
      tl.c_ready = 1'b0;
      #1;
      chk("t2_c_valid", tl.c_valid, 1);
      chk("t2_wb_beat", wb_beat, i);
      chk("t2_c_data", tl.c.data, 32'hCAFE_0000 + i);
      @(negedge clock);
      chk("t2_stall_beat", wb_beat, i);
      chk("t2_stall_data", tl.c.data, 32'hCAFE_0000 + i);
      tl.c_ready = 1'b1;
      @(negedge clock);
    end
    tl.c_ready = 1'b0;
    chk("t2_c_drop", tl.c_valid, 0);
    chk("t2_c_beats", c_cnt - c0, 4);
    chk("t2_rel_wait_d_ready", tl.d_ready, 1);
    chk("t2_wb_wrap", wb_beat, 0);
    chk("t2_no_early_acq", tl.a_valid, 0);
    drive_d(D_RELEASE_ACK, 3'd0, 4'd0, 32'h0);
    chk("t2_acq_valid", tl.a_valid, 1);
    chk("t2_acq_addr", tl.a.address, 32'h3000);
    chk("t2_acq_param", tl.a.param, BTOT);
    a_hs();
    drive_d(D_GRANT, {1'b0, TOB}, 4'd5, 32'h0);
    chk("t2_no_refill", refill_valid, 0);
    chk("t2_e_valid", tl.e_valid, 1);
    chk("t2_e_sink", tl.e.sink, 5);
    e_hs();
    chk("t2_done", done, 1);
    chk("t2_done_cap", done_cap, TOB);

    // Probe accepted in GRANT before the first D beat
    send_req(32'h4000, NTOB, 1'b0, 32'h0, 3'd0);
    a_hs();
    set_probe(4'd1, 32'h4000);
    probe_perm = TTON;
    #1 chk("t3_b_ready", tl.b_ready, 1);
    c0 = c_cnt;
    @(negedge clock);
    tl.b_valid = 1'b0;
    probe_perm = BTON;
    #1;
    chk("t3_pack_valid", tl.c_valid, 1);
    chk("t3_pack_opcode", tl.c.opcode, C_PROBE_ACK);
    chk("t3_pack_param", tl.c.param, TTON);
    chk("t3_pack_addr", tl.c.address, 32'h4000);
    chk("t3_pack_source", tl.c.source, 1);
    chk("t3_pack_size", tl.c.size, 6);
    chk("t3_pack_d_ready", tl.d_ready, 0);
    tl.c_ready = 1'b1;
    @(negedge clock);
    tl.c_ready = 1'b0;
    chk("t3_pack_drop", tl.c_valid, 0);
    chk("t3_pack_count", c_cnt - c0, 1);
    chk("t3_back_in_grant", tl.d_ready, 1);
    for (int i = 0; i < 4; i++) begin
      drive_d(D_GRANT_DATA, {1'b0, TON}, 4'd7, 32'h5500_0000 + i);
      chk("t3_refill_beat", refill_beat, i);
      chk("t3_refill_data", refill_data, 32'h5500_0000 + i);
    end
    chk("t3_e_sink", tl.e.sink, 7);
    e_hs();
    chk("t3_done", done, 1);
    chk("t3_done_cap", done_cap, TON);

    // Probe and request together in IDLE: probe first
    set_probe(4'd3, 32'h6000);
    probe_perm = NTON;
    req_valid = 1'b1; req_addr = 32'h5000; req_grow = NTOT; req_wb = 1'b0;
    #1;
    chk("t4_req_blocked", req_ready, 0);
    chk("t4_b_ready", tl.b_ready, 1);
    @(negedge clock);
    tl.b_valid = 1'b0;
    #1;
    chk("t4_pack_valid", tl.c_valid, 1);
    chk("t4_pack_param", tl.c.param, NTON);
    chk("t4_pack_addr", tl.c.address, 32'h6000);
    chk("t4_req_wait", req_ready, 0);
    tl.c_ready = 1'b1;
    @(negedge clock);
    tl.c_ready = 1'b0;
    #1 chk("t4_req_ready", req_ready, 1);
    @(negedge clock);
    req_valid = 1'b0;
    chk("t4_acq_valid", tl.a_valid, 1);
    chk("t4_acq_addr", tl.a.address, 32'h5000);
    a_hs();
    a0 = a_cnt;

    // Reset pulse mid-GRANT
    drive_d(D_GRANT_DATA, {1'b0, TOB}, 4'd2, 32'h1111);
    chk("t4_refill_pre", refill_valid, 1);
    chk("t4_cap_pre", done_cap, TOB);
    chk("t4_wb_beat_pre", wb_beat, 1);
    reset_n = 1'b0;
    #1;
    chk("t4_rst_valids", {tl.a_valid, tl.c_valid, tl.e_valid}, 0);
    chk("t4_rst_readies", {req_ready, tl.b_ready, tl.d_ready}, 0);
    chk("t4_rst_refill", refill_valid, 0);
    chk("t4_rst_done_cap", done_cap, 0);
    chk("t4_rst_cnt", wb_beat, 0);
    chk("t4_rst_err", err, 0);
    @(negedge clock);
    reset_n = 1'b1;
    #1 chk("t4_idle_after_rst", req_ready, 1);
    repeat (3) @(negedge clock);
    chk("t4_quiet", {tl.a_valid, tl.c_valid, tl.e_valid}, 0);
    chk("t4_no_a_traffic", a_cnt, a0);

    // Unexpected D opcode while waiting for ReleaseAck
    send_req(32'h8000, NTOT, 1'b1, 32'h7000, BTOB);
    tl.c_ready = 1'b1;
    c0 = c_cnt;
    repeat (4) @(negedge clock);
    tl.c_ready = 1'b0;
    chk("t5_c_beats", c_cnt - c0, 4);
    chk("t5_rel_wait", tl.d_ready, 1);
    chk("t5_err_pre", err, 0);
    drive_d(D_ACCESS_ACK_DATA, 3'd0, 4'd0, 32'h0BAD);
    chk("t5_err", err, 1);
    chk("t5_stay_d_ready", tl.d_ready, 1);
    chk("t5_no_acq", tl.a_valid, 0);
    drive_d(D_RELEASE_ACK, 3'd0, 4'd0, 32'h0);
    chk("t5_acq_after", tl.a_valid, 1);
    chk("t5_err_sticky", err, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
